// File: rtl/gemv_pkg.sv
// gemv_pkg: shared types and default sizing for the GEMV host controller.
//   GEMV_DW      - data word width
//   GEMV_SZ      - array dimension
//   GEMV_TIMEOUT - default WAIT watchdog limit (used with GEMV_TIMEOUT_EN)
package gemv_pkg;

  localparam int GEMV_DW = 16;
  localparam int GEMV_SZ = 3;

  localparam int GEMV_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_W,
    START,
    WAIT,
    DRAIN
  } state_e;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemv_out_ser.sv
// gemv_out_ser: captures the wrapper's parallel result vector on ld_i and
// streams it out one word per valid/ready handshake.
//   clk_i, rst_i        - clock, synchronous active-high reset
//   ld_i, res_i[SZ]     - load strobe and parallel result
//   out_valid_o/out_ready_i/out_data_o/out_last_o - serial result stream
//   done_o              - handshake of the last word this cycle
module gemv_out_ser #(
  parameter int DW = gemv_pkg::GEMV_DW,
  parameter int SZ = gemv_pkg::GEMV_SZ
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ld_i,
  input  logic [DW-1:0] res_i [SZ],
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          done_o
);
  import gemv_pkg::*;

  localparam int SW = clog2_min1(SZ);

  logic [DW-1:0] res_q [SZ];
  logic [SW-1:0] idx_q;
  logic          vld_q;
  logic          hs, last;

  // Result buffer has no reset; contents are only meaningful once loaded.
  for (genvar gi = 0; gi < SZ; gi++) begin : g_lane
    always_ff @(posedge clk_i) begin
      if (ld_i) res_q[gi] <= res_i[gi];
    end
  end

  assign last = (idx_q == SW'(SZ-1));
  assign hs   = vld_q & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      idx_q <= '0;
    end else if (ld_i) begin
      vld_q <= 1'b1;
      idx_q <= '0;
    end else if (hs) begin
      if (last) begin
        vld_q <= 1'b0;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = res_q[idx_q];
  assign out_last_o  = vld_q & last;
  assign done_o      = hs & last;

endmodule

// File: rtl/gemv_host_ctrl.sv
// gemv_host_ctrl: host-side initiator for the GEMV array wrapper.
// Loads A (row-major, SZ*SZ words) then W (SZ words) from a serial stream,
// pulses arr_en, waits for arr_valid, then streams the SZ results back.
//   in_valid/in_ready/in_data            - serial input stream
//   out_valid/out_ready/out_data/out_last - serial result stream
//   arr_A/arr_W/arr_en                    - wrapper inputs and start pulse
//   arr_O/arr_valid                       - wrapper result and done pulse
//   busy - not IDLE;  err - sticky WAIT timeout
// Optional macro GEMV_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES;
// without it err is tied low and WAIT exits only on arr_valid.
module gemv_host_ctrl #(
  parameter int DW             = gemv_pkg::GEMV_DW,
  parameter int SZ             = gemv_pkg::GEMV_SZ,
  parameter int TIMEOUT_CYCLES = gemv_pkg::GEMV_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [DW-1:0] arr_A [SZ*SZ],
  output logic [DW-1:0] arr_W [SZ],
  output logic          arr_en,
  input  logic [DW-1:0] arr_O [SZ],
  input  logic          arr_valid,
  output logic          busy,
  output logic          err
);
  import gemv_pkg::*;

  localparam int NA = SZ*SZ;
  localparam int IW = clog2_min1(NA);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, wr_idx;
  logic          in_ready_q, in_ready_d;
  logic          in_hs, ld, drain_done, tmo;
  logic [DW-1:0] a_q [NA];
  logic [DW-1:0] w_q [SZ];

  assign in_hs = in_valid & in_ready_q;

`ifdef GEMV_TIMEOUT_EN
  localparam int TW = clog2_min1(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmr_q;
  logic          err_q;

  // arr_valid on the limit cycle takes priority over the timeout.
  assign tmo = (state_q == WAIT) && !arr_valid && (tmr_q == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= (state_q == WAIT) ? tmr_q + 1'b1 : '0;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ld      = 1'b0;
    case (state_q)
      IDLE: if (in_hs) begin
        state_d = LOAD_A;
        idx_d   = IW'(1);
      end
      LOAD_A: if (in_hs) begin
        if (idx_q == IW'(NA-1)) begin
          idx_d   = '0;
          state_d = LOAD_W;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LOAD_W: if (in_hs) begin
        // idx returns to 0 so IDLE always writes slot 0 next job.
        if (idx_q == IW'(SZ-1)) begin
          idx_d   = '0;
          state_d = START;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (arr_valid) begin
          ld      = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      DRAIN: if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready is registered off the next state, so it never depends on in_valid.
  assign in_ready_d = (state_d == IDLE) || (state_d == LOAD_A) || (state_d == LOAD_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Operand storage: written only on accepted words, so it stays stable
  // from START until the next job's first word.
  assign wr_idx = (state_q == IDLE) ? '0 : idx_q;

  for (genvar gi = 0; gi < NA; gi++) begin : g_a
    always_ff @(posedge clk) begin
      if (in_hs && (state_q != LOAD_W) && (wr_idx == IW'(gi))) a_q[gi] <= in_data;
    end
  end

  for (genvar gi = 0; gi < SZ; gi++) begin : g_w
    always_ff @(posedge clk) begin
      if (in_hs && (state_q == LOAD_W) && (idx_q == IW'(gi))) w_q[gi] <= in_data;
    end
  end

  assign arr_A    = a_q;
  assign arr_W    = w_q;
  assign arr_en   = (state_q == START);
  assign busy     = (state_q != IDLE);
  assign in_ready = in_ready_q;

  gemv_out_ser #(.DW(DW), .SZ(SZ)) u_ser (
    .clk_i       (clk),
    .rst_i       (rst),
    .ld_i        (ld),
    .res_i       (arr_O),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .done_o      (drain_done)
  );

endmodule

// File: tb/tb_gemv_host_ctrl.sv
module tb_gemv_host_ctrl;
  import gemv_pkg::*;

  localparam int DW  = GEMV_DW;
  localparam int SZ  = GEMV_SZ;
  localparam int NA  = SZ*SZ;
  localparam int LAT = 3;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic [DW-1:0] arr_A [NA];
  logic [DW-1:0] arr_W [SZ];
  logic [DW-1:0] arr_O [SZ];
  logic          arr_en, arr_valid, busy, err;
  logic          model_valid, stray_valid;

  assign arr_valid = model_valid | stray_valid;

  always #5 clk = ~clk;

  gemv_host_ctrl #(.DW(DW), .SZ(SZ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .arr_A(arr_A), .arr_W(arr_W), .arr_en(arr_en),
    .arr_O(arr_O), .arr_valid(arr_valid),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            en_cnt = 0;
  int            cd = 0;
  int            k = 0;
  logic [DW-1:0] pend [SZ];
  bit            wrap_on = 1'b1;
  bit            bp_mode = 1'b0;
  logic [3:0]    pat = 4'b1001;
  bit            in_hs_seen;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  int            ja [NA];
  int            jw [SZ];

  // One clock: scoreboard/monitor at negedge, wrapper model + out_ready at posedge+1.
  task automatic cyc();
    logic [DW-1:0] acc;
    beat_t e;
    @(negedge clk);
    in_hs_seen = in_valid && in_ready && !rst;
    if (rst) begin
      cd = 0;
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (prev_stall) begin
          total++;
          if (out_data !== prev_d || out_last !== prev_l) begin
            bad++;
            $display("FAIL stall_hold: got data=%0d last=%0b, required data=%0d last=%0b",
                     out_data, out_last, prev_d, prev_l);
          end
        end
        if (out_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got data=%0d last=%0b, required no beat", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.d || out_last !== e.l) begin
              bad++;
              $display("FAIL result_beat: got data=%0d last=%0b, required data=%0d last=%0b",
                       out_data, out_last, e.d, e.l);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
      if (arr_en) begin
        en_cnt++;
        for (int i = 0; i < SZ; i++) begin
          acc = '0;
          for (int j = 0; j < SZ; j++) acc = acc + arr_A[i*SZ+j] * arr_W[j];
          pend[i] = acc;
        end
        cd = LAT;
      end
    end
    @(posedge clk);
    #1;
    model_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0 && wrap_on) begin
        model_valid = 1'b1;
        arr_O = pend;
      end
    end
    out_ready = bp_mode ? pat[k % 4] : 1'b1;
    k++;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      cyc();
      n++;
    end while (!in_hs_seen && n < 200);
    in_valid = 1'b0;
    total++;
    if (!in_hs_seen) begin
      bad++;
      $display("FAIL send_accept: word %0d not accepted within %0d cycles", d, n);
    end
  endtask

  // Streams ja/jw; optionally pushes golden results and injects a stray done pulse.
  task automatic send_job(input bit gap, input bit expect_out, input int stray_at);
    int acc;
    if (expect_out) begin
      for (int i = 0; i < SZ; i++) begin
        acc = 0;
        for (int j = 0; j < SZ; j++) acc += ja[i*SZ+j] * jw[j];
        exp_q.push_back({DW'(acc), (i == SZ-1)});
      end
    end
    for (int i = 0; i < NA+SZ; i++) begin
      if (i == stray_at) begin
        stray_valid = 1'b1;
        cyc();
        stray_valid = 1'b0;
      end
      send(DW'((i < NA) ? ja[i] : jw[i-NA]));
      if (gap) cyc();
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      cyc();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || busy || out_valid) begin
      bad++;
      $display("FAIL %s_drain: %0d beats pending busy=%0b out_valid=%0b, required 0/0/0",
               nm, exp_q.size(), busy, out_valid);
    end
  endtask

  task automatic set_seq_a();
    for (int i = 0; i < NA; i++) ja[i] = i + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %0b required 0", out_last); end
    if (arr_en !== 1'b0) begin bad++; $display("FAIL rst_arr_en: got %0b required 0", arr_en); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b required 0", busy); end
    if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b required 0", err); end
    rst = 1'b0;
    cyc();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_basic();
    int e0 = en_cnt;
    set_seq_a();
    for (int j = 0; j < SZ; j++) jw[j] = 1;
    send_job(1'b0, 1'b1, -1);
    drain("basic");
    total++;
    if (en_cnt - e0 !== 1) begin bad++; $display("FAIL basic_en_pulses: got %0d required 1", en_cnt - e0); end
  endtask

  task automatic test_backpressure();
    int e0 = en_cnt;
    bp_mode = 1'b1;
    set_seq_a();
    for (int j = 0; j < SZ; j++) jw[j] = 1;
    send_job(1'b1, 1'b1, -1);
    drain("bp");
    bp_mode = 1'b0;
    total++;
    if (en_cnt - e0 !== 1) begin bad++; $display("FAIL bp_en_pulses: got %0d required 1", en_cnt - e0); end
  endtask

  task automatic test_reset_mid_load();
    int e0 = en_cnt;
    for (int i = 0; i < 5; i++) send(DW'(i + 1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0b required 0", busy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %0b required 1", in_ready); end
    for (int i = 0; i < NA; i++) ja[i] = ((i / SZ) == (i % SZ)) ? 1 : 0;
    for (int j = 0; j < SZ; j++) jw[j] = 4 + j;
    send_job(1'b0, 1'b1, -1);
    drain("midrst");
    total++;
    if (en_cnt - e0 !== 1) begin bad++; $display("FAIL midrst_en_pulses: got %0d required 1", en_cnt - e0); end
  endtask

  task automatic test_stray_done();
    stray_valid = 1'b1;
    cyc();
    stray_valid = 1'b0;
    cyc();
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL stray_idle_busy: got %0b required 0", busy); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stray_idle_out_valid: got %0b required 0", out_valid); end
    set_seq_a();
    jw[0] = 1; jw[1] = 2; jw[2] = 3;
    send_job(1'b0, 1'b1, 3);
    drain("stray");
  endtask

  task automatic test_back_to_back();
    int e0 = en_cnt;
    set_seq_a();
    jw[0] = 2; jw[1] = 0; jw[2] = 1;
    send_job(1'b0, 1'b1, -1);
    jw[0] = 0; jw[1] = 1; jw[2] = 0;
    send_job(1'b0, 1'b1, -1);
    drain("b2b");
    total++;
    if (en_cnt - e0 !== 2) begin bad++; $display("FAIL b2b_en_pulses: got %0d required 2", en_cnt - e0); end
  endtask

`ifdef GEMV_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    wrap_on = 1'b0;
    set_seq_a();
    for (int j = 0; j < SZ; j++) jw[j] = 1;
    send_job(1'b0, 1'b0, -1);
    while (!err && n < 40) begin
      cyc();
      n++;
    end
    total += 3;
    if (err !== 1'b1 || n < TMO || n > TMO + 1) begin
      bad++;
      $display("FAIL tmo_err: got err=%0b after %0d cycles, required err=1 after %0d..%0d", err, n, TMO, TMO + 1);
    end
    if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %0b required 0", busy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL tmo_in_ready: got %0b required 1", in_ready); end
    repeat (4) cyc();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %0b required 1", err); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wrap_on = 1'b1;
    cyc();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %0b required 0", err); end
  endtask
`else
  task automatic test_err_absent();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_tied: got %0b required 0", err); end
  endtask
`endif

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    model_valid = 1'b0;
    stray_valid = 1'b0;
    for (int i = 0; i < SZ; i++) arr_O[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_load();
    test_stray_done();
    test_back_to_back();
`ifdef GEMV_TIMEOUT_EN
    test_timeout();
`else
    test_err_absent();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
